ld_st_addr_unit: RTL and testbench
==================================

# ld_st_addr_unit

Consumer end of the load/store ordering queue: pops the next reservation-station tag from the 4-bit tag FIFO and waits for that station's operands. It then computes the effective address, performs the memory access, and, for loads, broadcasts the result on the CDB. It serialises memory operations in queue order, one in flight at a time, and returns the station to the free pool when the operation completes.

## Interface
- TAG_W, 4, tag width; matches the FIFO entry width
- DATA_W, 32, base/data/address width
- IMM_W, 16, offset width; sign-extended to DATA_W
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- q_empty  in  1  tag FIFO empty
- q_tag  in  TAG_W  FIFO head, valid the cycle after q_rd_en
- q_rd_en  out  1  pop request to the FIFO
- rs_sel  out  TAG_W  station being inspected; equals cur_tag
- rs_busy  in  1  selected station allocated
- rs_is_store  in  1  selected station holds a store
- rs_base_valid, rs_base  in  1, DATA_W  base operand ready / value
- rs_imm  in  IMM_W  offset
- rs_sdata_valid, rs_sdata  in  1, DATA_W  store data ready / value
- mem_req, mem_we  out  1, 1  memory request / write enable
- mem_addr, mem_wdata  out  DATA_W  address / store data
- mem_ack  in  1  memory completion; may arrive in the same cycle as mem_req
- mem_rdata  in  DATA_W  load data, valid with mem_ack
- cdb_req  out  1  CDB arbitration request
- cdb_grant  in  1  CDB grant
- cdb_tag, cdb_data  out  TAG_W, DATA_W  broadcast tag / load data
- rs_release  out  1  one-cycle pulse; frees station cur_tag
- tag_drop  out  1  one-cycle pulse; popped tag was not allocated

## Operation
States: IDLE, POP, WAIT, MEM, CDB.
- IDLE: q_rd_en = !q_empty (combinational). If q_rd_en, go to POP.
- POP: latch cur_tag <= q_tag, then go to WAIT.
- WAIT:
  - If !rs_busy: pulse tag_drop, go to IDLE.
  - Ready = rs_base_valid && (!rs_is_store || rs_sdata_valid).
  - When ready: register mem_addr = rs_base + sext(rs_imm), truncated mod 2^DATA_W. Register mem_we = rs_is_store and mem_wdata = rs_sdata. Latch is_st. Go to MEM.
  - Otherwise stay in WAIT.
- MEM: mem_req = 1; mem_addr, mem_we and mem_wdata are held stable.
  - On mem_ack with is_st: rs_release = 1 that cycle, go to IDLE.
  - On mem_ack with a load: latch cdb_data <= mem_rdata, go to CDB.
- CDB: cdb_req = 1, cdb_tag = cur_tag.
  - On cdb_grant: rs_release = 1 that cycle, go to IDLE.
- q_rd_en is asserted only in IDLE. The FIFO is never popped while an operation is in flight.
- Address overflow wraps; no exception is raised.

## Timing
- Reset values: state IDLE; cur_tag 0; all data and address registers 0; all req, pulse and enable outputs 0.
- Reset is asynchronous: asserting rst in any state drops mem_req and cdb_req immediately. Any in-flight operation is abandoned with no release pulse.
- Minimum load latency, q_rd_en to rs_release, is 4 cycles:
  - c0: IDLE
  - c1: POP
  - c2: WAIT, ready
  - c3: MEM, ack
  - c4: CDB, grant
- Minimum store latency is 3 cycles (release in c3).
- The next pop occurs at the earliest in the cycle after release.
- mem_req and cdb_req stay asserted until ack or grant. No timeout.
- q_empty rising in POP is ignored; the tag was already popped.
- rs_release and tag_drop are never asserted together. Each lasts exactly one cycle.

## Test plan
- Load: tag 5, base 0x1000, imm 0xFFFC, ack in the same cycle as the request, rdata 0xDEADBEEF, grant on the first request cycle.
  - mem_addr 0x0FFC, mem_we 0.
  - cdb_tag 5, cdb_data 0xDEADBEEF.
  - rs_release 4 cycles after q_rd_en.
- Store: tag 3, base 0xFFFFFFF0, imm 0x0020, sdata becomes valid 3 cycles after base.
  - mem_req rises only after sdata_valid.
  - mem_addr 0x00000010, mem_wdata is correct, mem_we 1.
  - No cdb_req; release coincides with ack.
- Ordering and backpressure: queue tags 2, 7, 1; ack delayed 5 cycles and grant delayed 2 cycles per operation.
  - Releases occur in order 2, 7, 1.
  - q_rd_en is never high outside IDLE.
- Drop: popped tag 9 with rs_busy = 0.
  - tag_drop pulses one cycle in WAIT, with no mem_req.
  - The next tag is popped in the following cycle.
- Reset in MEM: assert rst asynchronously between clock edges while mem_req = 1.
  - mem_req falls without waiting for a clock edge.
  - After deassertion, the unit sits in IDLE and pops again once q_empty = 0.

Source files
------------

// File: rtl/ld_st_addr_unit.sv
`default_nettype none
// ============================================================================
//  Module   : ld_st_addr_unit
//  Purpose  : Consumer end of the load/store ordering queue. Pops a
//             reservation-station tag and waits for that station's operands.
//             It then computes base + sext(imm), performs the memory access
//             and, for loads, broadcasts the result on the CDB. One operation
//             is in flight at a time, and they complete in queue order.
//  Ports    : clk, rst                       clock, async active-high reset
//             q_empty, q_tag, q_rd_en        tag FIFO interface
//             rs_sel, rs_busy, rs_is_store,
//             rs_base*, rs_imm, rs_sdata*    station operand lookup
//             mem_req/we/addr/wdata/ack/rdata memory port
//             cdb_req/grant/tag/data         common data bus
//             rs_release, tag_drop           station free / bogus-tag pulses
//  Revision : 1.0  initial release
// ============================================================================
module ld_st_addr_unit #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              q_empty,
    input  logic [TAG_W-1:0]  q_tag,
    output logic              q_rd_en,
    output logic [TAG_W-1:0]  rs_sel,
    input  logic              rs_busy,
    input  logic              rs_is_store,
    input  logic              rs_base_valid,
    input  logic [DATA_W-1:0] rs_base,
    input  logic [IMM_W-1:0]  rs_imm,
    input  logic              rs_sdata_valid,
    input  logic [DATA_W-1:0] rs_sdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cdb_req,
    input  logic              cdb_grant,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic              rs_release,
    output logic              tag_drop
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_POP  = 3'd1,
        S_WAIT = 3'd2,
        S_MEM  = 3'd3,
        S_CDB  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [TAG_W-1:0]  r_cur_tag;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_cdb_data;
    logic              r_we;
    logic              r_is_st;
    logic              w_ready;
    logic [DATA_W-1:0] w_imm_sext;
    logic [DATA_W-1:0] w_eff_addr;

    // Stores additionally need their data operand before issuing.
    assign w_ready    = rs_base_valid && (!rs_is_store || rs_sdata_valid);
    assign w_imm_sext = {{(DATA_W-IMM_W){rs_imm[IMM_W-1]}}, rs_imm};
    // Wraps silently on overflow.
    assign w_eff_addr = rs_base + w_imm_sext;

    // ------------------------------------------------------------------
    // Next-state and handshake outputs. Requests decode from state alone,
    // so an asynchronous reset removes them without waiting for a clock.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        q_rd_en     = 1'b0;
        mem_req     = 1'b0;
        cdb_req     = 1'b0;
        rs_release  = 1'b0;
        tag_drop    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!q_empty) begin
                    q_rd_en     = 1'b1;
                    w_state_nxt = S_POP;
                end
            end
            S_POP: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (!rs_busy) begin
                    tag_drop    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_ready) begin
                    w_state_nxt = S_MEM;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    if (r_is_st) begin
                        rs_release  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_CDB;
                    end
                end
            end
            S_CDB: begin
                cdb_req = 1'b1;
                if (cdb_grant) begin
                    rs_release  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Tag captured in POP: the FIFO head becomes valid one cycle after the pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_tag <= '0;
        end else if (r_state == S_POP) begin
            r_cur_tag <= q_tag;
        end
    end

    // The request fields are frozen on WAIT->MEM and stay stable for the whole
    // MEM phase, whatever the station outputs do afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_is_st <= 1'b0;
        end else if (r_state == S_WAIT && rs_busy && w_ready) begin
            r_addr  <= w_eff_addr;
            r_wdata <= rs_sdata;
            r_we    <= rs_is_store;
            r_is_st <= rs_is_store;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cdb_data <= '0;
        end else if (r_state == S_MEM && mem_ack && !r_is_st) begin
            r_cdb_data <= mem_rdata;
        end
    end

    assign rs_sel    = r_cur_tag;
    assign cdb_tag   = r_cur_tag;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_we    = r_we;
    assign cdb_data  = r_cdb_data;

endmodule
`default_nettype wire

// File: tb/tb_ld_st_addr_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ld_st_addr_unit
//  Purpose  : Self-checking bench for ld_st_addr_unit. It models the tag FIFO,
//             the reservation stations, memory and the CDB at the transaction
//             level, and it predicts each operation's handshakes, address and
//             data from the descriptor that was queued.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ld_st_addr_unit;

    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;
    localparam int IMM_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              q_empty;
    logic [TAG_W-1:0]  q_tag;
    logic              q_rd_en;
    logic [TAG_W-1:0]  rs_sel;
    logic              rs_busy, rs_is_store, rs_base_valid, rs_sdata_valid;
    logic [DATA_W-1:0] rs_base, rs_sdata;
    logic [IMM_W-1:0]  rs_imm;
    logic              mem_req, mem_we, mem_ack;
    logic [DATA_W-1:0] mem_addr, mem_wdata, mem_rdata;
    logic              cdb_req, cdb_grant;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              rs_release, tag_drop;

    ld_st_addr_unit #(.TAG_W(TAG_W), .DATA_W(DATA_W), .IMM_W(IMM_W)) dut (
        .clk(clk), .rst(rst),
        .q_empty(q_empty), .q_tag(q_tag), .q_rd_en(q_rd_en),
        .rs_sel(rs_sel), .rs_busy(rs_busy), .rs_is_store(rs_is_store),
        .rs_base_valid(rs_base_valid), .rs_base(rs_base), .rs_imm(rs_imm),
        .rs_sdata_valid(rs_sdata_valid), .rs_sdata(rs_sdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .rs_release(rs_release), .tag_drop(tag_drop)
    );

    always #5 clk = ~clk;

    // One queued memory operation with its operand/response timing.
    typedef struct {
        logic [3:0]  tag;
        bit          busy;
        bit          st;
        logic [31:0] base;
        logic [15:0] imm;
        logic [31:0] sdata;
        int          bd;     // cycles into WAIT before base is valid
        int          sd;     // further cycles before store data is valid
        int          ad;     // mem_req cycles before ack (0 = same cycle)
        int          gd;     // cdb_req cycles before grant
        logic [31:0] rdata;
    } op_t;

    op_t fifo[$];
    op_t cur;
    bit  inflight, pend, rdy_seen, mem_done;
    int  wc, mcnt, gcnt, cyc_n, pop_cyc, last_lat, last_drop_cyc, drop_gap;
    int  n_rel, n_drop;
    int  n_chk = 0;
    int  n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic op_t mk(input logic [3:0] tag, input bit busy, input bit st,
                               input logic [31:0] base, input logic [15:0] imm,
                               input logic [31:0] sdata, input int bd, input int sd,
                               input int ad, input int gd, input logic [31:0] rdata);
        op_t o;
        o.tag = tag; o.busy = busy; o.st = st; o.base = base; o.imm = imm;
        o.sdata = sdata; o.bd = bd; o.sd = sd; o.ad = ad; o.gd = gd; o.rdata = rdata;
        return o;
    endfunction

    // Effective address: signed offset added with 32-bit wraparound.
    function automatic logic [31:0] ea(input op_t o);
        return o.base + int'($signed(o.imm));
    endfunction

    // Drive all inputs for the coming edge (called just after a falling edge).
    task automatic drive();
        if (pend) begin
            cur      = fifo.pop_front();
            pend     = 1'b0;
            q_tag    = cur.tag;
            wc       = 1;
            mcnt     = 0;
            gcnt     = 0;
            rdy_seen = 1'b0;
            mem_done = 1'b0;
        end else begin
            wc++;
        end
        q_empty        = (fifo.size() == 0);
        rs_busy        = (rs_sel == cur.tag) && cur.busy;
        rs_is_store    = cur.st;
        rs_base        = cur.base;
        rs_imm         = cur.imm;
        rs_sdata       = cur.sdata;
        rs_base_valid  = (wc >= 2 + cur.bd);
        rs_sdata_valid = (wc >= 2 + cur.bd + cur.sd);
        mem_rdata      = cur.rdata;
        mem_ack        = mem_req && (mcnt == cur.ad);
        if (mem_req) mcnt++;
        cdb_grant      = cdb_req && (gcnt == cur.gd);
        if (cdb_req) gcnt++;
        cyc_n++;
    endtask

    // Compare this cycle's outputs against the transaction model, then advance it.
    task automatic check();
        bit rdy, exp_rd, exp_drop, exp_mreq, exp_creq, exp_rel;
        rdy      = inflight && cur.busy && (wc >= 2) && rs_base_valid &&
                   (!cur.st || rs_sdata_valid);
        exp_rd   = !inflight && (fifo.size() != 0);
        exp_drop = inflight && !cur.busy && (wc == 2);
        exp_mreq = inflight && cur.busy && rdy_seen && !mem_done;
        exp_creq = inflight && mem_done && !cur.st;
        exp_rel  = (exp_mreq && mem_ack && cur.st) || (exp_creq && cdb_grant);
        chk("q_rd_en", q_rd_en, exp_rd);
        chk("tag_drop", tag_drop, exp_drop);
        chk("mem_req", mem_req, exp_mreq);
        chk("cdb_req", cdb_req, exp_creq);
        chk("rs_release", rs_release, exp_rel);
        if (exp_mreq) begin
            chk("mem_addr", mem_addr, ea(cur));
            chk("mem_we", mem_we, cur.st);
            chk("mem_wdata", mem_wdata, cur.sdata);
        end
        if (exp_creq) begin
            chk("cdb_tag", cdb_tag, cur.tag);
            chk("cdb_data", cdb_data, cur.rdata);
        end
        if (exp_rel) begin
            chk("release_tag", rs_sel, cur.tag);
            last_lat = cyc_n - pop_cyc;
            n_rel++;
            inflight = 1'b0;
        end
        if (exp_drop) begin
            last_drop_cyc = cyc_n;
            n_drop++;
            inflight = 1'b0;
        end
        if (exp_mreq && mem_ack) mem_done = 1'b1;
        if (exp_rd) begin
            pend     = 1'b1;
            inflight = 1'b1;
            pop_cyc  = cyc_n;
            if (last_drop_cyc >= 0) begin
                drop_gap      = cyc_n - last_drop_cyc;
                last_drop_cyc = -1;
            end
        end
        rdy_seen = rdy_seen || rdy;
    endtask

    task automatic cyc();
        @(negedge clk);
        drive();
        #1;
        check();
    endtask

    task automatic run_ops(input string tag, input int maxc);
        int n = 0;
        while ((fifo.size() != 0 || inflight || pend) && n < maxc) begin
            cyc();
            n++;
        end
        chk(tag, (n < maxc), 1'b1);
    endtask

    initial begin
        int rel0, drop0, n;
        op_t idle_op;
        idle_op = mk(4'd0, 1'b0, 1'b0, 32'd0, 16'd0, 32'd0, 0, 0, 0, 0, 32'd0);
        cur = idle_op;
        inflight = 0; pend = 0; rdy_seen = 0; mem_done = 0;
        wc = 0; mcnt = 0; gcnt = 0; cyc_n = 0; pop_cyc = 0;
        last_lat = -1; last_drop_cyc = -1; drop_gap = -1; n_rel = 0; n_drop = 0;
        rst = 1'b1; q_empty = 1'b1; q_tag = '0; rs_busy = 0; rs_is_store = 0;
        rs_base_valid = 0; rs_base = '0; rs_imm = '0; rs_sdata_valid = 0;
        rs_sdata = '0; mem_ack = 0; mem_rdata = '0; cdb_grant = 0;

        // Reset state.
        @(negedge clk); @(negedge clk);
        chk("rst_q_rd_en", q_rd_en, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_cdb_req", cdb_req, 1'b0);
        chk("rst_pulses", {rs_release, tag_drop}, 2'b00);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_cdb_data", cdb_data, 32'd0);
        chk("rst_tag", {rs_sel, cdb_tag}, 8'h00);
        rst = 1'b0;

        // Minimum-latency load with a wrapping negative offset.
        fifo.push_back(mk(4'd5, 1, 0, 32'h0000_1000, 16'hFFFC, 32'h1111_2222,
                          0, 0, 0, 0, 32'hDEAD_BEEF));
        run_ops("load_timeout", 50);
        chk("load_latency", last_lat, 4);

        // Store whose data becomes valid 3 cycles after its base.
        fifo.push_back(mk(4'd3, 1, 1, 32'hFFFF_FFF0, 16'h0020, 32'hCAFE_F00D,
                          0, 3, 0, 0, 32'h0));
        run_ops("store_timeout", 50);
        chk("store_latency", last_lat, 6);

        // Minimum-latency store.
        fifo.push_back(mk(4'd10, 1, 1, 32'h0000_0100, 16'h0004, 32'h0BAD_CAFE,
                          0, 0, 0, 0, 32'h0));
        run_ops("store_min_timeout", 50);
        chk("store_min_latency", last_lat, 3);

        // Ordering under memory and CDB backpressure.
        rel0 = n_rel;
        fifo.push_back(mk(4'd2, 1, 0, 32'h0000_2000, 16'h0010, 32'h0, 0, 0, 5, 2, 32'h0000_0222));
        fifo.push_back(mk(4'd7, 1, 1, 32'h0000_3000, 16'h8000, 32'h7777_7777, 1, 2, 5, 2, 32'h0));
        fifo.push_back(mk(4'd1, 1, 0, 32'h0000_4000, 16'h7FFF, 32'h0, 2, 0, 5, 2, 32'h0000_0111));
        run_ops("order_timeout", 200);
        chk("order_releases", n_rel - rel0, 3);

        // Unallocated tag: dropped, next tag popped the following cycle.
        drop0 = n_drop;
        fifo.push_back(mk(4'd9, 0, 0, 32'h0, 16'h0, 32'h0, 0, 0, 0, 0, 32'h0));
        fifo.push_back(mk(4'd4, 1, 0, 32'h0000_0040, 16'hFFC0, 32'h0, 0, 0, 1, 1, 32'h4444_4444));
        run_ops("drop_timeout", 50);
        chk("drop_count", n_drop - drop0, 1);
        chk("drop_to_pop", drop_gap, 1);

        // Randomized batches, including back-to-back ops and occasional drops.
        for (int b = 0; b < 10; b++) begin
            int k;
            k = $urandom_range(1, 5);
            for (int i = 0; i < k; i++) begin
                fifo.push_back(mk(4'($urandom_range(0, 15)), $urandom_range(0, 9) != 0,
                                  1'($urandom_range(0, 1)), $urandom, 16'($urandom),
                                  $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                                  $urandom_range(0, 4), $urandom_range(0, 3), $urandom));
            end
            run_ops("rand_timeout", 400);
            repeat ($urandom_range(0, 2)) cyc();
        end

        // Asynchronous reset while a request is outstanding.
        fifo.push_back(mk(4'd6, 1, 0, 32'h0000_0600, 16'h0006, 32'h0, 0, 0, 30, 0, 32'h6666_6666));
        n = 0;
        do begin
            cyc();
            n++;
        end while (!mem_req && n < 20);
        chk("pre_rst_mem_req", mem_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_mem_req", mem_req, 1'b0);
        chk("async_cdb_req", cdb_req, 1'b0);
        chk("async_release", rs_release, 1'b0);
        @(negedge clk); @(negedge clk);
        fifo.delete();
        inflight = 0; pend = 0; rdy_seen = 0; mem_done = 0;
        cur = idle_op; q_empty = 1'b1; mem_ack = 0; cdb_grant = 0;
        rst = 1'b0;
        repeat (3) cyc();
        rel0 = n_rel;
        fifo.push_back(mk(4'd6, 1, 0, 32'h0000_0600, 16'h0006, 32'h0, 0, 0, 0, 0, 32'h6666_6666));
        run_ops("post_rst_timeout", 50);
        chk("post_rst_release", n_rel - rel0, 1);
        chk("post_rst_latency", last_lat, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
